// File: rtl/spi_pkg.sv
// Shared definitions for the SPI transaction arbiter.
// Holds the sequencer state encoding, field widths, the reserved (invalid)
// slave address, the default transfer/guard timing, and a helper that sizes
// the round-robin pointer.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_START   = 3'd2,
    ST_XFER    = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_GUARD   = 3'd5,
    ST_ERR     = 3'd6
  } state_t;

  localparam int          ADDR_W       = 2;
  localparam int          MODE_W       = 2;
  localparam int          BYTE_W       = 8;
  localparam logic [1:0]  ADDR_INVALID = 2'd3;

  // 8 bits x 2 clk per SCLK, and two idle cycles so chip-select can drop.
  localparam int DEF_XFER_CYCLES  = 16;
  localparam int DEF_GUARD_CYCLES = 2;

  // Pointer width; a single requester still needs a 1-bit pointer.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_rr_arbiter.sv
// Round-robin requester selection.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   req_valid    : per-requester request
//   update       : grant is being taken this cycle; advance the pointer
//   grant        : one-hot grant (combinational from req_valid and pointer)
//   any          : at least one request is present
module spi_rr_arbiter
  import spi_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic               update,
  output logic [NUM_REQ-1:0] grant,
  output logic               any
);

  localparam int PTR_W = ptr_width(NUM_REQ);

  logic [PTR_W-1:0]   ptr_r;
  logic [PTR_W-1:0]   idx_s;
  logic [NUM_REQ-1:0] grant_s;
  logic               found_s;

  // First valid requester at or above the pointer, wrapping at NUM_REQ.
  always_comb begin
    grant_s = {NUM_REQ{1'b0}};
    idx_s   = {PTR_W{1'b0}};
    found_s = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found_s && req_valid[(int'(ptr_r) + i) % NUM_REQ]) begin
        found_s = 1'b1;
        grant_s[(int'(ptr_r) + i) % NUM_REQ] = 1'b1;
        idx_s   = PTR_W'((int'(ptr_r) + i) % NUM_REQ);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Pointer moves just past the requester that was granted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_r <= {PTR_W{1'b0}};
    end else if (update && found_s) begin
      if (idx_s == PTR_W'(NUM_REQ - 1)) begin
        ptr_r <= {PTR_W{1'b0}};
      end else begin
        ptr_r <= idx_s + PTR_W'(1'b1);
      end
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign grant = grant_s;
  assign any   = found_s;

endmodule

// File: rtl/spi_txn_arbiter.sv
// Shares one SPI master among NUM_REQ requesters, one byte per transaction.
// A requester is picked round-robin, its address/data/mode are latched, the
// master is loaded and started, the byte is timed, and the master RX byte is
// returned to the owner. Slave address 3 is answered with an error response
// without touching the master.
// Ports:
//   clk, reset_n               : clock, asynchronous active-low reset
//   req_valid/addr/data/mode   : per-requester request and fields (packed)
//   req_ready                  : one-hot acceptance pulse
//   rsp_valid/rsp_data/rsp_err : one-hot response pulse, RX byte, bad address
//   spi_load/start             : master strobes
//   spi_data/addr/cpol/cpha    : master transfer setup, held between grants
//   spi_rx_data                : master RX byte
//   busy                       : sequencer not idle
module spi_txn_arbiter
  import spi_pkg::*;
#(
  parameter int NUM_REQ      = 3,
  parameter int XFER_CYCLES  = DEF_XFER_CYCLES,
  parameter int GUARD_CYCLES = DEF_GUARD_CYCLES
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [ADDR_W*NUM_REQ-1:0] req_addr,
  input  logic [BYTE_W*NUM_REQ-1:0] req_data,
  input  logic [MODE_W*NUM_REQ-1:0] req_mode,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [BYTE_W-1:0]         rsp_data,
  output logic                      rsp_err,
  output logic                      spi_load,
  output logic                      spi_start,
  output logic [BYTE_W-1:0]         spi_data,
  output logic [ADDR_W-1:0]         spi_addr,
  output logic                      spi_cpol,
  output logic                      spi_cpha,
  input  logic [BYTE_W-1:0]         spi_rx_data,
  output logic                      busy
);

  localparam int CNT_W = $clog2(XFER_CYCLES + GUARD_CYCLES + 1) + 1;
  localparam logic [CNT_W-1:0] XFER_LAST  = CNT_W'(XFER_CYCLES - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST =
    CNT_W'((GUARD_CYCLES > 0) ? (GUARD_CYCLES - 1) : 0);

  state_t             state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [NUM_REQ-1:0] owner_r;
  logic [ADDR_W-1:0]  addr_r;
  logic [BYTE_W-1:0]  data_r;
  logic [MODE_W-1:0]  mode_r;

  logic [NUM_REQ-1:0] req_ready_r;
  logic [NUM_REQ-1:0] rsp_valid_r;
  logic [BYTE_W-1:0]  rsp_data_r;
  logic               rsp_err_r;
  logic               spi_load_r;
  logic               spi_start_r;
  logic [BYTE_W-1:0]  spi_data_r;
  logic [ADDR_W-1:0]  spi_addr_r;
  logic [MODE_W-1:0]  spi_mode_r;
  logic               busy_r;

  logic [NUM_REQ-1:0] grant_s;
  logic               any_s;
  logic               update_s;
  logic [ADDR_W-1:0]  sel_addr_s;
  logic [BYTE_W-1:0]  sel_data_s;
  logic [MODE_W-1:0]  sel_mode_s;

  // Grants are only taken while idle, so the pointer only moves then.
  assign update_s = (state_r == ST_IDLE);

  spi_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .update    (update_s),
    .grant     (grant_s),
    .any       (any_s)
  );

  // AND-OR mux of the granted requester's fields; the grant is one-hot.
  always_comb begin
    sel_addr_s = {ADDR_W{1'b0}};
    sel_data_s = {BYTE_W{1'b0}};
    sel_mode_s = {MODE_W{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_addr_s = sel_addr_s | ({ADDR_W{grant_s[i]}} & req_addr[ADDR_W*i +: ADDR_W]);
      sel_data_s = sel_data_s | ({BYTE_W{grant_s[i]}} & req_data[BYTE_W*i +: BYTE_W]);
      sel_mode_s = sel_mode_s | ({MODE_W{grant_s[i]}} & req_mode[MODE_W*i +: MODE_W]);
    end
  end

  // Transaction sequencer: grant, load, start, time the byte, respond, guard.
  // Every output is a register written here, so each strobe appears the
  // cycle after the state that requests it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      owner_r     <= {NUM_REQ{1'b0}};
      addr_r      <= {ADDR_W{1'b0}};
      data_r      <= {BYTE_W{1'b0}};
      mode_r      <= {MODE_W{1'b0}};
      req_ready_r <= {NUM_REQ{1'b0}};
      rsp_valid_r <= {NUM_REQ{1'b0}};
      rsp_data_r  <= {BYTE_W{1'b0}};
      rsp_err_r   <= 1'b0;
      spi_load_r  <= 1'b0;
      spi_start_r <= 1'b0;
      spi_data_r  <= {BYTE_W{1'b0}};
      spi_addr_r  <= {ADDR_W{1'b0}};
      spi_mode_r  <= {MODE_W{1'b0}};
      busy_r      <= 1'b0;
    end else begin
      req_ready_r <= {NUM_REQ{1'b0}};
      rsp_valid_r <= {NUM_REQ{1'b0}};
      spi_load_r  <= 1'b0;
      spi_start_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (any_s) begin
            req_ready_r <= grant_s;
            owner_r     <= grant_s;
            addr_r      <= sel_addr_s;
            data_r      <= sel_data_s;
            mode_r      <= sel_mode_s;
            busy_r      <= 1'b1;
            if (sel_addr_s == ADDR_INVALID) begin
              state_r <= ST_ERR;
            end else begin
              state_r <= ST_LOAD;
            end
          end else begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        ST_LOAD: begin
          // Master setup changes only here, so it stays put through the
          // transfer and the following idle time.
          spi_load_r <= 1'b1;
          spi_data_r <= data_r;
          spi_addr_r <= addr_r;
          spi_mode_r <= mode_r;
          state_r    <= ST_START;
        end
        ST_START: begin
          spi_start_r <= 1'b1;
          cnt_r       <= {CNT_W{1'b0}};
          state_r     <= ST_XFER;
        end
        ST_XFER: begin
          if (cnt_r == XFER_LAST) begin
            state_r <= ST_CAPTURE;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1'b1);
          end
        end
        ST_CAPTURE: begin
          rsp_valid_r <= owner_r;
          rsp_data_r  <= spi_rx_data;
          rsp_err_r   <= 1'b0;
          cnt_r       <= {CNT_W{1'b0}};
          if (GUARD_CYCLES == 0) begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_GUARD;
          end
        end
        ST_GUARD: begin
          if (cnt_r == GUARD_LAST) begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1'b1);
          end
        end
        ST_ERR: begin
          // Bad address: answer immediately, master untouched.
          rsp_valid_r <= owner_r;
          rsp_err_r   <= 1'b1;
          rsp_data_r  <= {BYTE_W{1'b0}};
          busy_r      <= 1'b0;
          state_r     <= ST_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready = req_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_data  = rsp_data_r;
  assign rsp_err   = rsp_err_r;
  assign spi_load  = spi_load_r;
  assign spi_start = spi_start_r;
  assign spi_data  = spi_data_r;
  assign spi_addr  = spi_addr_r;
  assign spi_cpol  = spi_mode_r[1];
  assign spi_cpha  = spi_mode_r[0];
  assign busy      = busy_r;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Self-checking bench for spi_txn_arbiter. Expected responses are queued when
// a request is posted and compared when rsp_valid appears; per-transaction
// timing and master-setup stability are checked cycle by cycle.
module tb_spi_txn_arbiter;

  localparam int         NUM_REQ = 3;
  localparam int         XFER    = 16;
  localparam int         GUARD   = 2;
  localparam logic [7:0] KEY     = 8'h99;

  logic                 clk;
  logic                 reset_n;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [2*NUM_REQ-1:0] req_addr;
  logic [8*NUM_REQ-1:0] req_data;
  logic [2*NUM_REQ-1:0] req_mode;
  logic [NUM_REQ-1:0]   rsp_valid;
  logic [7:0]           rsp_data;
  logic                 rsp_err;
  logic                 spi_load;
  logic                 spi_start;
  logic [7:0]           spi_data;
  logic [1:0]           spi_addr;
  logic                 spi_cpol;
  logic                 spi_cpha;
  logic [7:0]           spi_rx_data;
  logic                 busy;

  spi_txn_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .XFER_CYCLES  (XFER),
    .GUARD_CYCLES (GUARD)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .req_mode    (req_mode),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err),
    .spi_load    (spi_load),
    .spi_start   (spi_start),
    .spi_data    (spi_data),
    .spi_addr    (spi_addr),
    .spi_cpol    (spi_cpol),
    .spi_cpha    (spi_cpha),
    .spi_rx_data (spi_rx_data),
    .busy        (busy)
  );

  // Slave model: returns the loaded byte scrambled by a fixed key.
  assign spi_rx_data = spi_data ^ KEY;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    int         who;
    logic [7:0] rx;
    logic       err;
  } exp_t;

  exp_t sb[$];

  logic [1:0] last_addr;
  logic [7:0] last_data;
  logic [1:0] last_mode;

  function automatic logic [11:0] cur_fields();
    return {spi_addr, spi_cpol, spi_cpha, spi_data};
  endfunction

  function automatic logic [11:0] last_fields();
    return {last_addr, last_mode, last_data};
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input int who);
    logic [NUM_REQ-1:0] v;
    v = {NUM_REQ{1'b0}};
    v[who] = 1'b1;
    return v;
  endfunction

  task automatic push_exp(input int who, input logic [1:0] a, input logic [7:0] d);
    exp_t e;
    e.who = who;
    e.err = (a == 2'd3);
    e.rx  = e.err ? 8'h00 : (d ^ KEY);
    sb.push_back(e);
  endtask

  task automatic post_req(input int who, input logic [1:0] a, input logic [7:0] d,
                          input logic [1:0] m);
    req_addr[2*who +: 2] = a;
    req_data[8*who +: 8] = d;
    req_mode[2*who +: 2] = m;
    req_valid[who]       = 1'b1;
    push_exp(who, a, d);
  endtask

  // Response monitor: every rsp_valid pulse must match the head of the queue.
  always @(negedge clk) begin
    if (reset_n && (rsp_valid != {NUM_REQ{1'b0}})) begin
      if (sb.size() == 0) begin
        check_eq("rsp_unexpected", 32'(rsp_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq("rsp_who",  32'(rsp_valid), 32'(onehot(e.who)));
        check_eq("rsp_data", 32'(rsp_data),  32'(e.rx));
        check_eq("rsp_err",  32'(rsp_err),   32'(e.err));
      end
    end
  end

  // Follows one transaction from acceptance to the end of its guard time.
  task automatic expect_txn(input int who, input logic [1:0] a, input logic [7:0] d,
                            input logic [1:0] m, input bit keep, output int t_acc);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (req_ready != {NUM_REQ{1'b0}}) begin
        seen = 1'b1;
        break;
      end
    end
    t_acc = cyc;
    check_eq("ready", 32'(req_ready), 32'(onehot(who)));
    if (!seen) return;
    check_eq("hold_at_grant", 32'(cur_fields()), 32'(last_fields()));
    if (!keep) req_valid[who] = 1'b0;
    if (a == 2'd3) begin
      @(negedge clk);
      check_eq("err_rsp_time", 32'(rsp_valid), 32'(onehot(who)));
      check_eq("err_no_strobe", 32'({spi_load, spi_start}), 32'd0);
      check_eq("err_hold", 32'(cur_fields()), 32'(last_fields()));
    end else begin
      @(negedge clk);
      check_eq("load_strobe", 32'({spi_load, spi_start}), 32'b10);
      check_eq("load_fields", 32'(cur_fields()), 32'({a, m, d}));
      last_addr = a;
      last_data = d;
      last_mode = m;
      @(negedge clk);
      check_eq("start_strobe", 32'({spi_load, spi_start, busy}), 32'b011);
      for (int k = 0; k < XFER; k++) begin
        @(negedge clk);
        check_eq("xfer_quiet",
                 32'({busy, rsp_valid, spi_load, spi_start, cur_fields()}),
                 32'({1'b1, {NUM_REQ{1'b0}}, 2'b00, last_fields()}));
      end
      @(negedge clk);
      check_eq("rsp_time", 32'({busy, rsp_valid}), 32'({1'b1, onehot(who)}));
      for (int g = 1; g <= GUARD; g++) begin
        @(negedge clk);
        check_eq("guard_hold", 32'({busy, cur_fields()}),
                 32'({(g < GUARD) ? 1'b1 : 1'b0, last_fields()}));
      end
    end
  endtask

  task automatic assert_reset();
    @(posedge clk);
    #2;
    reset_n   = 1'b0;
    last_addr = 2'd0;
    last_data = 8'h00;
    last_mode = 2'd0;
  endtask

  task automatic release_reset();
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  int t0, t1, t2;

  initial begin
    reset_n   = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    req_mode  = '0;
    last_addr = 2'd0;
    last_data = 8'h00;
    last_mode = 2'd0;

    // Reset state.
    repeat (3) @(negedge clk);
    check_eq("reset_outputs",
             32'({req_ready, rsp_valid, rsp_data, rsp_err, spi_load, spi_start,
                  spi_data, spi_addr, spi_cpol, spi_cpha, busy}), 32'd0);
    release_reset();

    // Single request.
    @(negedge clk);
    post_req(0, 2'd1, 8'hA5, 2'b00);
    expect_txn(0, 2'd1, 8'hA5, 2'b00, 1'b0, t0);

    // Contention from reset release: order 0,1,2, 22 cycles apart.
    assert_reset();
    post_req(0, 2'd0, 8'h12, 2'b01);
    post_req(1, 2'd1, 8'h34, 2'b10);
    post_req(2, 2'd2, 8'h56, 2'b11);
    release_reset();
    expect_txn(0, 2'd0, 8'h12, 2'b01, 1'b0, t0);
    expect_txn(1, 2'd1, 8'h34, 2'b10, 1'b0, t1);
    expect_txn(2, 2'd2, 8'h56, 2'b11, 1'b0, t2);
    check_eq("spacing_01", 32'(t1 - t0), 32'd22);
    check_eq("spacing_12", 32'(t2 - t1), 32'd22);

    // Fairness: req0 held, req2 arrives during req0's transfer.
    post_req(0, 2'd2, 8'h11, 2'b10);
    fork
      expect_txn(0, 2'd2, 8'h11, 2'b10, 1'b1, t0);
      begin
        repeat (10) @(negedge clk);
        post_req(2, 2'd0, 8'hF0, 2'b01);
      end
    join
    push_exp(0, 2'd2, 8'h11);
    expect_txn(2, 2'd0, 8'hF0, 2'b01, 1'b0, t1);
    expect_txn(0, 2'd2, 8'h11, 2'b10, 1'b0, t2);

    // Invalid address, then the next grant two cycles after acceptance.
    post_req(1, 2'd3, 8'hDE, 2'b11);
    post_req(2, 2'd1, 8'h0F, 2'b00);
    expect_txn(1, 2'd3, 8'hDE, 2'b11, 1'b0, t0);
    expect_txn(2, 2'd1, 8'h0F, 2'b00, 1'b0, t1);
    check_eq("err_next_grant", 32'(t1 - t0), 32'd2);

    // Mode hold across back-to-back transactions.
    post_req(0, 2'd0, 8'h81, 2'b11);
    post_req(1, 2'd2, 8'h7E, 2'b01);
    expect_txn(0, 2'd0, 8'h81, 2'b11, 1'b0, t0);
    expect_txn(1, 2'd2, 8'h7E, 2'b01, 1'b0, t1);

    // Reset during the transfer: abandoned, then regranted from pointer 0.
    post_req(0, 2'd2, 8'h5A, 2'b10);
    t0 = -1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (req_ready != {NUM_REQ{1'b0}}) begin
        t0 = cyc;
        break;
      end
    end
    check_eq("mid_ready", 32'(req_ready), 32'(onehot(0)));
    repeat (7) @(negedge clk);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("async_reset",
             32'({req_ready, rsp_valid, rsp_data, rsp_err, spi_load, spi_start,
                  spi_data, spi_addr, spi_cpol, spi_cpha, busy}), 32'd0);
    check_eq("reset_at_t8", 32'(cyc - t0), 32'd8);
    last_addr = 2'd0;
    last_data = 8'h00;
    last_mode = 2'd0;
    post_req(1, 2'd0, 8'hC3, 2'b01);
    release_reset();
    expect_txn(0, 2'd2, 8'h5A, 2'b10, 1'b0, t1);
    expect_txn(1, 2'd0, 8'hC3, 2'b01, 1'b0, t2);

    repeat (5) @(negedge clk);
    check_eq("scoreboard_empty", 32'(sb.size()), 32'd0);
    check_eq("final_idle", 32'({busy, rsp_valid}), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (checks=%0d)", n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
